// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and size helpers for the convolution MAC sequencer.
package conv_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

   function automatic int calc_n(input int ksize);
      return ksize * ksize;
   endfunction

   function automatic int calc_addr_w(input int ksize);
      return (ksize * ksize <= 1) ? 1 : $clog2(ksize * ksize);
   endfunction

endpackage

// File: rtl/conv_mac_sequencer_if.sv
// conv_mac_sequencer_if: controller, kernel and downstream signals of the sequencer; batch ports with CONV_SEQ_BATCH_EN.
interface conv_mac_sequencer_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 4
);
   logic              i_start;
   logic              o_busy;
   logic [ADDR_W-1:0] o_tap_addr;
   logic              o_tap_valid;
   logic              o_acc_clr;
   logic [WIDTH-1:0]  i_sum;
   logic [WIDTH-1:0]  o_result;
   logic              o_result_valid;
   logic              i_out_ready;
   logic              o_done;
`ifdef CONV_SEQ_BATCH_EN
   logic [15:0]       i_win_count;
   logic [15:0]       o_win_idx;

   modport slave (
      input  i_start, i_sum, i_out_ready, i_win_count,
      output o_busy, o_tap_addr, o_tap_valid, o_acc_clr, o_result, o_result_valid, o_done, o_win_idx
   );

   modport master (
      output i_start, i_sum, i_out_ready, i_win_count,
      input  o_busy, o_tap_addr, o_tap_valid, o_acc_clr, o_result, o_result_valid, o_done, o_win_idx
   );
`else
   modport slave (
      input  i_start, i_sum, i_out_ready,
      output o_busy, o_tap_addr, o_tap_valid, o_acc_clr, o_result, o_result_valid, o_done
   );

   modport master (
      output i_start, i_sum, i_out_ready,
      input  o_busy, o_tap_addr, o_tap_valid, o_acc_clr, o_result, o_result_valid, o_done
   );
`endif
endinterface

// File: rtl/conv_seq_counter.sv
// conv_seq_counter: loadable down-counter with terminal flag, saturating at zero.
module conv_seq_counter #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   input  logic          i_dec,
   output logic [CW-1:0] o_cnt,
   output logic          o_zero
);

   logic [CW-1:0] r_cnt;

   // load takes priority over decrement; counting stops at zero
   always_ff @(posedge clk) begin
      if (rst) r_cnt <= '0;
      else if (i_load) r_cnt <= i_load_val;
      else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: walks one KSIZE x KSIZE window through the MAC kernel and hands the sum downstream;
// CONV_SEQ_BATCH_EN adds back-to-back multi-window runs.
module conv_mac_sequencer
   import conv_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int KSIZE    = 3,
   parameter int PIPE_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   conv_mac_sequencer_if.slave bus
);

   localparam int N      = calc_n(KSIZE);
   localparam int ADDR_W = calc_addr_w(KSIZE);
   localparam int CW     = 4;
   localparam logic [CW-1:0] TAP_LAST   = CW'(N - 1);
   localparam logic [CW-1:0] DRAIN_LAST = CW'((PIPE_LAT == 0) ? 0 : PIPE_LAT - 1);

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_result;
   logic [CW-1:0]    w_cnt, w_load_val;
   logic             w_cnt_zero, w_load, w_dec, w_accept, w_more;

   // one counter serves both phases: tap count while issuing, pipeline wait while draining
   conv_seq_counter #(.CW(CW)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_cnt      (w_cnt),
      .o_zero     (w_cnt_zero)
   );

`ifdef CONV_SEQ_BATCH_EN
   logic [15:0] r_win_idx, r_win_cnt;

   // window bookkeeping: a zero count still runs one window
   always_ff @(posedge clk) begin
      if (rst) begin
         r_win_idx <= '0;
         r_win_cnt <= '0;
      end else if (r_state == IDLE && bus.i_start) begin
         r_win_idx <= '0;
         r_win_cnt <= (bus.i_win_count == '0) ? 16'd1 : bus.i_win_count;
      end else if (w_accept && w_more) begin
         r_win_idx <= r_win_idx + 16'd1;
      end
   end

   assign w_more        = (17'(r_win_idx) + 17'd1) < 17'(r_win_cnt);
   assign bus.o_win_idx = r_win_idx;
`else
   assign w_more = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end

   // next state and counter control; the counter reloads on every ISSUE entry and at the ISSUE->DRAIN hand-off
   always_comb begin
      w_next     = r_state;
      w_accept   = (r_state == OUTPUT) && bus.i_out_ready;
      unique case (r_state)
         IDLE:    w_next = bus.i_start ? ISSUE : IDLE;
         ISSUE:   w_next = w_cnt_zero ? ((PIPE_LAT == 0) ? OUTPUT : DRAIN) : ISSUE;
         DRAIN:   w_next = w_cnt_zero ? OUTPUT : DRAIN;
         OUTPUT:  w_next = w_accept ? (w_more ? ISSUE : IDLE) : OUTPUT;
         default: w_next = IDLE;
      endcase
      w_load     = (w_next == ISSUE && r_state != ISSUE) || (r_state == ISSUE && w_cnt_zero);
      w_load_val = (r_state == ISSUE) ? DRAIN_LAST : TAP_LAST;
      w_dec      = (r_state == ISSUE) || (r_state == DRAIN);
   end

   // capture the kernel sum on the cycle the result becomes valid, hold until accepted
   always_ff @(posedge clk) begin
      if (rst) r_result <= '0;
      else if (w_next == OUTPUT && r_state != OUTPUT) r_result <= bus.i_sum;
   end

   // outputs decoded from state; address counts up while the counter counts down
   always_comb begin
      bus.o_busy         = (r_state != IDLE);
      bus.o_tap_valid    = (r_state == ISSUE);
      bus.o_tap_addr     = (r_state == ISSUE) ? ADDR_W'(TAP_LAST - w_cnt) : '0;
      bus.o_acc_clr      = (r_state == ISSUE) && (w_cnt == TAP_LAST);
      bus.o_result       = r_result;
      bus.o_result_valid = (r_state == OUTPUT);
      bus.o_done         = w_accept && !w_more;
   end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// tb_conv_mac_sequencer: directed bench with a cycle-timeline model of the sequencer (KSIZE=3/PIPE_LAT=2) and
// literal checks on a KSIZE=1/PIPE_LAT=0 instance; batch checks when CONV_SEQ_BATCH_EN is defined.
module tb_conv_mac_sequencer;
   import conv_pkg::*;

   localparam int N  = 9;
   localparam int PL = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic chk_en = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_done = 0;
   int   n_tap = 0;
   int   n_rv = 0;
   int   q_idx[$];

   always #5 clk = ~clk;

   conv_mac_sequencer_if #(.WIDTH(32), .ADDR_W(calc_addr_w(3))) bus ();
   conv_mac_sequencer_if #(.WIDTH(32), .ADDR_W(calc_addr_w(1))) bus1 ();

   conv_mac_sequencer #(.WIDTH(32), .KSIZE(3), .PIPE_LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   conv_mac_sequencer #(.WIDTH(32), .KSIZE(1), .PIPE_LAT(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input int lim, input string name);
      for (int i = 0; i < lim && bus.o_busy; i++) tick();
      chk(name, 32'(bus.o_busy), 32'd0);
   endtask

   // model: m_t is the cycle position inside the current window (0 = idle)
   int          m_t = 0;
   int          m_left = 0;
   int          m_idx = 0;
   logic        m_rv = 1'b0;
   logic [31:0] m_res = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_t <= 0; m_rv <= 1'b0; m_res <= '0; m_left <= 0; m_idx <= 0;
      end else if (m_rv) begin
         if (bus.i_out_ready) begin
            m_rv <= 1'b0;
            if (m_left > 1) begin
               m_left <= m_left - 1; m_idx <= m_idx + 1; m_t <= 1;
            end else m_t <= 0;
         end
      end else if (m_t == 0) begin
         if (bus.i_start) begin
            m_t <= 1; m_idx <= 0;
`ifdef CONV_SEQ_BATCH_EN
            m_left <= (bus.i_win_count == 0) ? 1 : int'(bus.i_win_count);
`else
            m_left <= 1;
`endif
         end
      end else if (m_t == N + PL) begin
         m_rv <= 1'b1; m_res <= bus.i_sum; m_t <= m_t + 1;
      end else m_t <= m_t + 1;
   end

   // compare every cycle against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(bus.o_busy), 32'(m_t != 0));
         chk("tap_valid", 32'(bus.o_tap_valid), 32'(m_t >= 1 && m_t <= N));
         chk("tap_addr", 32'(bus.o_tap_addr), (m_t >= 1 && m_t <= N) ? 32'(m_t - 1) : 32'd0);
         chk("acc_clr", 32'(bus.o_acc_clr), 32'(m_t == 1));
         chk("result_valid", 32'(bus.o_result_valid), 32'(m_rv));
         chk("done", 32'(bus.o_done), 32'(m_rv && bus.i_out_ready && m_left == 1));
         if (m_rv) chk("result", bus.o_result, m_res);
`ifdef CONV_SEQ_BATCH_EN
         if (m_t != 0) chk("win_idx", 32'(bus.o_win_idx), 32'(m_idx));
`endif
      end
   end

   // event tallies for the run-level checks
   always @(negedge clk) begin
      n_done += int'(bus.o_done);
      n_tap  += int'(bus.o_tap_valid);
      n_rv   += int'(bus.o_result_valid);
`ifdef CONV_SEQ_BATCH_EN
      if (bus.o_result_valid) q_idx.push_back(int'(bus.o_win_idx));
`endif
   end

   initial begin
      int d0, t0, r0;
      bus.i_start = 0; bus.i_sum = 0; bus.i_out_ready = 0;
      bus1.i_start = 0; bus1.i_sum = 0; bus1.i_out_ready = 0;
`ifdef CONV_SEQ_BATCH_EN
      bus.i_win_count = 0; bus1.i_win_count = 0;
`endif
      repeat (3) tick();
      chk("rst_busy", 32'(bus.o_busy), 0);
      chk("rst_valid", 32'(bus.o_tap_valid), 0);
      chk("rst_rv", 32'(bus.o_result_valid), 0);
      chk("rst_done", 32'(bus.o_done), 0);
      chk("rst_result", bus.o_result, 0);
      rst = 0;
      chk_en = 1;
      tick();
      // single window, late ready
      bus.i_start = 1;
      tick();
      bus.i_start = 0;
      for (int c = 1; c <= 11; c++) begin
         bus.i_sum = (c == 11) ? 32'h41200000 : 32'(c);
         if (c == 1) begin
            chk("t1_valid", 32'(bus.o_tap_valid), 1);
            chk("t1_clr", 32'(bus.o_acc_clr), 1);
            chk("t1_addr", 32'(bus.o_tap_addr), 0);
         end
         if (c == 9) begin
            chk("t9_addr", 32'(bus.o_tap_addr), 8);
            chk("t9_clr", 32'(bus.o_acc_clr), 0);
         end
         if (c == 10) chk("t10_valid", 32'(bus.o_tap_valid), 0);
         tick();
      end
      bus.i_sum = 32'hdeadbeef;
      chk("t12_rv", 32'(bus.o_result_valid), 1);
      chk("t12_result", bus.o_result, 32'h41200000);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_result", bus.o_result, 32'h41200000);
         chk("hold_done", 32'(bus.o_done), 0);
      end
      bus.i_out_ready = 1;
      #1;
      chk("accept_done", 32'(bus.o_done), 1);
      tick();
      bus.i_out_ready = 0;
      chk("after_busy", 32'(bus.o_busy), 0);
      // start held high through a window: second window starts from the IDLE cycle
      d0 = n_done; t0 = n_tap;
      bus.i_out_ready = 1;
      bus.i_start = 1;
      repeat (14) tick();
      bus.i_start = 0;
      wait_idle(40, "held_start_idle");
      chk("held_start_done", 32'(n_done - d0), 2);
      chk("held_start_taps", 32'(n_tap - t0), 18);
      // reset mid-ISSUE
      bus.i_out_ready = 0;
      bus.i_start = 1;
      tick();
      bus.i_start = 0;
      repeat (4) tick();
      d0 = n_done;
      rst = 1;
      tick();
      chk("mrst_busy", 32'(bus.o_busy), 0);
      chk("mrst_valid", 32'(bus.o_tap_valid), 0);
      chk("mrst_clr", 32'(bus.o_acc_clr), 0);
      chk("mrst_rv", 32'(bus.o_result_valid), 0);
      chk("mrst_result", bus.o_result, 0);
      rst = 0;
      tick();
      chk("mrst_no_done", 32'(n_done - d0), 0);
      d0 = n_done; t0 = n_tap;
      bus.i_out_ready = 1;
      bus.i_start = 1;
      tick();
      bus.i_start = 0;
      wait_idle(40, "fresh_idle");
      chk("fresh_taps", 32'(n_tap - t0), 9);
      chk("fresh_done", 32'(n_done - d0), 1);
      bus.i_out_ready = 0;
      // KSIZE=1, PIPE_LAT=0 instance
      bus1.i_start = 1;
      tick();
      bus1.i_start = 0;
      bus1.i_sum = 32'h3f800000;
      chk("k1_valid", 32'(bus1.o_tap_valid), 1);
      chk("k1_clr", 32'(bus1.o_acc_clr), 1);
      chk("k1_addr", 32'(bus1.o_tap_addr), 0);
      tick();
      bus1.i_sum = 32'h12345678;
      chk("k1_rv", 32'(bus1.o_result_valid), 1);
      chk("k1_result", bus1.o_result, 32'h3f800000);
      chk("k1_tap_off", 32'(bus1.o_tap_valid), 0);
      bus1.i_out_ready = 1;
      #1;
      chk("k1_done", 32'(bus1.o_done), 1);
      tick();
      bus1.i_out_ready = 0;
      chk("k1_idle", 32'(bus1.o_busy), 0);
`ifdef CONV_SEQ_BATCH_EN
      // three windows back to back, ready tied high
      d0 = n_done; t0 = n_tap; r0 = n_rv;
      q_idx.delete();
      bus.i_win_count = 16'd3;
      bus.i_out_ready = 1;
      bus.i_start = 1;
      tick();
      bus.i_start = 0;
      bus.i_win_count = 16'd0;
      wait_idle(100, "batch_idle");
      chk("batch_taps", 32'(n_tap - t0), 27);
      chk("batch_done", 32'(n_done - d0), 1);
      chk("batch_rv", 32'(n_rv - r0), 3);
      chk("batch_idx_n", 32'(q_idx.size()), 3);
      for (int i = 0; i < 3 && i < q_idx.size(); i++) chk("batch_idx", 32'(q_idx[i]), 32'(i));
      bus.i_out_ready = 0;
`else
      r0 = n_rv;
`endif
      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
